// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the RISC-V fetch front end.
//   ILEN          instruction width (32)
//   PC_STEP       byte distance between consecutive fetch words (4)
//   ENTRY_PC_W    PC field width stored in a queue entry (upper bound on XLEN)
//   fetch_entry_t one prefetch-queue entry {pc, instr}
package fetch_pkg;

   localparam int unsigned ILEN       = 32;
   localparam int unsigned PC_STEP    = 4;
   localparam int unsigned ENTRY_PC_W = 64;

   typedef struct packed {
      logic [ENTRY_PC_W-1:0] pc;
      logic [ILEN-1:0]       instr;
   } fetch_entry_t;

   localparam fetch_entry_t ENTRY_ZERO = '{pc: 64'h0, instr: 32'h0};

endpackage

// File: rtl/fetch_fifo_flush.sv
// fetch_fifo_flush: DEPTH-deep synchronous FIFO of fetch_entry_t with a
// single-cycle flush. Pointers wrap at DEPTH (power of two).
//   clk_i, rst_i   clock, asynchronous active-high reset
//   flush_i        empty the queue this cycle (wins over push)
//   push_i         write push_data_i at the tail (ignored when full)
//   pop_i          consume the head (ignored when empty)
//   head_o         head entry, all-zero while empty
//   valid_o        queue not empty
//   count_o        current occupancy
module fetch_fifo_flush
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  fetch_entry_t               push_data_i,
   input  logic                       pop_i,
   output fetch_entry_t               head_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_s, pop_s;

   assign push_s  = push_i && (count_q != FULL);
   assign pop_s   = pop_i && (count_q != {CW{1'b0}});
   assign valid_o = (count_q != {CW{1'b0}});
   assign count_o = count_q;

   // Pointer and occupancy next-state; flush returns the queue to empty.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push_s) wr_ptr_d = wr_ptr_q + PW'(1'b1);
         else        wr_ptr_d = wr_ptr_q;
         if (pop_s)  rd_ptr_d = rd_ptr_q + PW'(1'b1);
         else        rd_ptr_d = rd_ptr_q;
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; unreset because a slot is only read after it was written.
   always_ff @(posedge clk_i) begin
      if (push_s && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Head presentation, forced to zero while empty so outputs are defined.
   always_comb begin
      if (valid_o) head_o = mem_q[rd_ptr_q];
      else         head_o = ENTRY_ZERO;
   end

endmodule

// File: rtl/fetch_buffer_riscv.sv
// fetch_buffer_riscv: RISC-V instruction-fetch front end with prefetch queue.
// Owns the PC, issues word-aligned requests to an in-order variable-latency
// memory, queues returned words with their PCs and hands them to decode.
// A redirect flushes the queue and marks all in-flight responses stale.
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   branch_en_i, branch_pc_i       redirect request and target
//   imem_req_valid_o/ready_i/addr_o  fetch request channel
//   imem_rsp_valid_i, imem_rsp_data_i  in-order response channel
//   if_valid_o/ready_i, if_instr_o, if_pc_o  decode handshake
//   fetch_err_o                    misaligned-redirect pulse
// Build option FETCH_MISALIGN_CHECK_EN: reject redirects whose target is not
// word aligned and pulse fetch_err_o; otherwise the low two bits are cleared.
module fetch_buffer_riscv
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = 64,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            branch_en_i,
   input  logic [XLEN-1:0] branch_pc_i,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_rsp_valid_i,
   input  logic [ILEN-1:0] imem_rsp_data_i,
   output logic            if_valid_o,
   input  logic            if_ready_i,
   output logic [ILEN-1:0] if_instr_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic            fetch_err_o
);

   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, target_s;
   logic [CW-1:0]   inflight_q, inflight_d, drop_q, drop_d, count_s;
   logic [CW:0]     live_s;
   logic            redirect_s, req_fire_s, rsp_s, push_s, has_credit_s;
   fetch_entry_t    push_entry_s, head_s;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_s;
   assign misalign_s  = branch_en_i && (branch_pc_i[1:0] != 2'b00);
   assign redirect_s  = branch_en_i && !misalign_s;
   assign target_s    = branch_pc_i;
   assign fetch_err_o = misalign_s;
`else
   assign redirect_s  = branch_en_i;
   assign target_s    = branch_pc_i & ~(XLEN'(2'b11));
   assign fetch_err_o = 1'b0;
`endif

   // Entries already owed to the queue: occupied slots plus live (non-stale)
   // requests. Saturating inflight guards the counter against wrap.
   assign live_s       = {1'b0, count_s} + ({1'b0, inflight_q} - {1'b0, drop_q});
   assign has_credit_s = (live_s < (CW+1)'(DEPTH)) && (inflight_q != {CW{1'b1}});

   assign imem_req_valid_o = has_credit_s && !branch_en_i && !rst_i;
   assign imem_req_addr_o  = pc_q;
   assign req_fire_s       = imem_req_valid_o && imem_req_ready_i;
   // A response with nothing outstanding is spurious and ignored.
   assign rsp_s            = imem_rsp_valid_i && (inflight_q != {CW{1'b0}});

   assign push_entry_s.pc    = ENTRY_PC_W'(rsp_pc_q);
   assign push_entry_s.instr = imem_rsp_data_i;

   // PC, response-PC and in-flight bookkeeping next-state.
   always_comb begin
      pc_d       = pc_q;
      rsp_pc_d   = rsp_pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      push_s     = 1'b0;
      case ({req_fire_s, rsp_s})
         2'b10:   inflight_d = inflight_q + CW'(1'b1);
         2'b01:   inflight_d = inflight_q - CW'(1'b1);
         default: inflight_d = inflight_q;
      endcase
      if (redirect_s) begin
         // Every request still outstanding after this cycle is stale.
         pc_d     = target_s;
         rsp_pc_d = target_s;
         drop_d   = inflight_d;
      end else begin
         if (req_fire_s) pc_d = pc_q + XLEN'(PC_STEP);
         else            pc_d = pc_q;
         if (rsp_s && (drop_q != {CW{1'b0}})) begin
            drop_d = drop_q - CW'(1'b1);
         end else if (rsp_s) begin
            push_s   = 1'b1;
            rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
         end else begin
            drop_d = drop_q;
         end
      end
   end

   // Front-end state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q       <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= {CW{1'b0}};
         drop_q     <= {CW{1'b0}};
      end else begin
         pc_q       <= pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo_flush #(.DEPTH(DEPTH)) u_queue (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (redirect_s),
      .push_i      (push_s),
      .push_data_i (push_entry_s),
      .pop_i       (if_ready_i),
      .head_o      (head_s),
      .valid_o     (if_valid_o),
      .count_o     (count_s)
   );

   assign if_instr_o = head_s.instr;
   assign if_pc_o    = head_s.pc[XLEN-1:0];

endmodule

// File: tb/tb_fetch_buffer_riscv.sv
module tb_fetch_buffer_riscv;

   localparam int unsigned XLEN     = 64;
   localparam int unsigned DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        clk = 1'b0;
   logic        rst, branch_en, imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic        if_valid, if_ready, fetch_err;
   logic [63:0] branch_pc, imem_req_addr, if_pc;
   logic [31:0] imem_rsp_data, if_instr;

   always #5 clk = ~clk;

   fetch_buffer_riscv #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk_i(clk), .rst_i(rst), .branch_en_i(branch_en), .branch_pc_i(branch_pc),
      .imem_req_valid_o(imem_req_valid), .imem_req_ready_i(imem_req_ready),
      .imem_req_addr_o(imem_req_addr), .imem_rsp_valid_i(imem_rsp_valid),
      .imem_rsp_data_i(imem_rsp_data), .if_valid_o(if_valid), .if_ready_i(if_ready),
      .if_instr_o(if_instr), .if_pc_o(if_pc), .fetch_err_o(fetch_err)
   );

   typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
   typedef struct { logic [63:0] addr; bit stale; } pend_t;
   typedef struct { int due; logic [63:0] addr; } mreq_t;
   typedef struct { logic [63:0] pc; logic [31:0] instr; int cyc; } dlv_t;

   ent_t        mq[$];     // expected queue contents, head first
   pend_t       pend[$];   // requests the model expects to be outstanding
   mreq_t       memq[$];   // memory environment: accepted requests awaiting reply
   dlv_t        dlv[$];    // observed deliveries to decode
   logic [63:0] reqs[$];   // observed accepted request addresses
   logic [63:0] mpc;
   int          cyc, last_due, lat_min, lat_max;
   int          n_assert, n_fail;

   function automatic logic [31:0] memf(input logic [63:0] a);
      return a[31:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; branch_en = 1'b0; branch_pc = 64'h0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; if_ready = 1'b0;
      #1;
      chk("rst_if_valid", if_valid, 64'h0);
      chk("rst_req_valid", imem_req_valid, 64'h0);
      chk("rst_fetch_err", fetch_err, 64'h0);
      chk("rst_if_instr", if_instr, 64'h0);
      chk("rst_if_pc", if_pc, 64'h0);
      mq.delete(); pend.delete(); memq.delete();
      mpc = RESET_PC; last_due = cyc;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock cycle: inputs already driven by the caller at the negedge.
   task automatic step();
      logic        exp_rv, exp_err, redir, pop_e, rsp_v, req_acc;
      logic [63:0] tgt, acc_addr;
      int          live, due;
      pend_t       p;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1; imem_rsp_data = memf(memq[0].addr); memq.delete(0);
      end else begin
         imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
      end
      #1;
      live = 0;
      foreach (pend[i]) if (!pend[i].stale) live++;
`ifdef FETCH_MISALIGN_CHECK_EN
      redir   = branch_en && (branch_pc[1:0] == 2'b00);
      exp_err = branch_en && (branch_pc[1:0] != 2'b00);
      tgt     = branch_pc;
`else
      redir   = branch_en;
      exp_err = 1'b0;
      tgt     = {branch_pc[63:2], 2'b00};
`endif
      exp_rv = !branch_en && ((int'(DEPTH) - mq.size() - live) > 0);
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, mpc);
      chk("if_valid", if_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("if_pc", if_pc, mq[0].pc);
         chk("if_instr", if_instr, mq[0].instr);
      end
      chk("fetch_err", fetch_err, exp_err);
      if (if_valid && if_ready) dlv.push_back('{if_pc, if_instr, cyc});
      req_acc  = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      if (req_acc) reqs.push_back(acc_addr);
      pop_e = (mq.size() > 0) && if_ready;
      rsp_v = imem_rsp_valid;
      @(posedge clk);
      if (pop_e) mq.delete(0);
      if (rsp_v && pend.size() > 0) begin
         p = pend.pop_front();
         if (!p.stale && !redir) begin
            chk("no_overflow", mq.size() < int'(DEPTH), 64'h1);
            mq.push_back('{p.addr, memf(p.addr)});
         end
      end
      if (redir) begin
         mq.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         mpc = tgt;
      end else if (exp_rv && imem_req_ready) begin
         pend.push_back('{mpc, 1'b0});
         mpc = mpc + 64'd4;
      end
      if (req_acc) begin
         due = cyc + int'($urandom_range(lat_min, lat_max));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         memq.push_back('{due, acc_addr});
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] tgt, saved;
      n_assert = 0; n_fail = 0; cyc = 0; last_due = 0; lat_min = 1; lat_max = 1;

      // 1-cycle memory, decode always ready: 0,4,8,12 back to back.
      do_reset();
      if_ready = 1'b1; dlv.delete();
      repeat (10) step();
      chk("t1_count", dlv.size() >= 4, 64'h1);
      if (dlv.size() >= 4)
         for (int i = 0; i < 4; i++) begin
            chk("t1_pc", dlv[i].pc, 64'(4 * i));
            chk("t1_instr", dlv[i].instr, 64'(4 * i));
            chk("t1_consec", 64'(dlv[i].cyc - dlv[0].cyc), 64'(i));
         end

      // Decode stalled: exactly DEPTH requests, then in-order release.
      do_reset();
      reqs.delete(); dlv.delete();
      repeat (10) step();
      chk("t2_req_stop", 64'(reqs.size()), 64'(DEPTH));
      if_ready = 1'b1;
      repeat (8) step();
      chk("t2_count", dlv.size() >= 5, 64'h1);
      if (dlv.size() >= 5)
         for (int i = 0; i < 5; i++) chk("t2_order", dlv[i].pc, 64'(4 * i));

      // Latency 3, three in flight, redirect to 0x100.
      do_reset();
      lat_min = 3; lat_max = 3; if_ready = 1'b1; reqs.delete();
      for (int k = 0; k < 10 && reqs.size() < 3; k++) step();
      chk("t3_inflight", 64'(reqs.size()), 64'h3);
      branch_en = 1'b1; branch_pc = 64'h100;
      step();
      branch_en = 1'b0; dlv.delete();
      repeat (12) step();
      chk("t3_count", dlv.size() >= 1, 64'h1);
      if (dlv.size() >= 1) begin
         chk("t3_first_pc", dlv[0].pc, 64'h100);
         chk("t3_first_instr", dlv[0].instr, 64'h100);
      end

      // Redirect coinciding with a pop and a response.
      do_reset();
      lat_min = 1; lat_max = 1; if_ready = 1'b1;
      repeat (6) step();
      dlv.delete();
      branch_en = 1'b1; branch_pc = 64'h200;
      step();
      branch_en = 1'b0;
      chk("t4_pop_once", 64'(dlv.size()), 64'h1);
      chk("t4_empty", if_valid, 64'h0);
      repeat (6) step();
      chk("t4_count", dlv.size() >= 2, 64'h1);
      if (dlv.size() >= 2) chk("t4_next_pc", dlv[1].pc, 64'h200);

      // Redirect to the top word: address wraps to zero.
      reqs.delete();
      branch_en = 1'b1; branch_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      branch_en = 1'b0;
      repeat (4) step();
      chk("t5_count", reqs.size() >= 2, 64'h1);
      if (reqs.size() >= 2) begin
         chk("t5_addr0", reqs[0], 64'hFFFF_FFFF_FFFF_FFFC);
         chk("t5_addr1", reqs[1], 64'h0);
      end

      // Misaligned redirect target 0x102.
      repeat (4) step();
      reqs.delete(); saved = mpc;
      branch_en = 1'b1; branch_pc = 64'h102;
      #1;
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("t6_err_pulse", fetch_err, 64'h1);
`else
      chk("t6_err_tied", fetch_err, 64'h0);
`endif
      step();
      branch_en = 1'b0;
      chk("t6_err_gone", fetch_err, 64'h0);
      repeat (3) step();
      chk("t6_count", reqs.size() >= 1, 64'h1);
`ifdef FETCH_MISALIGN_CHECK_EN
      if (reqs.size() >= 1) chk("t6_unflushed", reqs[0], saved);
`else
      if (reqs.size() >= 1) chk("t6_aligned", reqs[0], 64'h100);
`endif

      // Randomised traffic with occasional redirects and resets.
      lat_min = 1; lat_max = 3;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         imem_req_ready = ($urandom_range(0, 99) < 70);
         if_ready       = ($urandom_range(0, 99) < 75);
         branch_en      = ($urandom_range(0, 99) < 4);
         tgt = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
         branch_pc = tgt;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
